// File: rtl/gemips_pipe_pkg.sv
// Shared constants for the GeMIPS pipeline hazard control logic.
package gemips_pipe_pkg;

    // Stage indices: IF is the youngest stage, WB the oldest.
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int NUM_STAGES_DEF = 5;

    // Bits needed to hold an index in 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_prio_enc.sv
// Highest-set-bit priority encoder: index of the most significant request.
module pipe_prio_enc #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// N-stage stall / flush / bubble controller with multi-cycle wait tracking,
// a wait watchdog and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import gemips_pipe_pkg::*;
#(
    parameter int NUM_STAGES  = NUM_STAGES_DEF,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] wait_start,
    input  logic [NUM_STAGES-1:0] wait_done,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic                  stall_cnt_clr,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic [NUM_STAGES-1:0] flush,
    output logic [NUM_STAGES-1:0] wait_pend,
    output logic                  wait_timeout,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int IW   = idx_width(NUM_STAGES);
    localparam int WD_W = idx_width(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [NUM_STAGES-1:0] wait_pend_reg;
    logic [NUM_STAGES-1:0] wait_act;
    logic [NUM_STAGES-1:0] above_f;
    logic [NUM_STAGES-1:0] below_f;
    logic [NUM_STAGES-1:0] defer_src;
    logic [NUM_STAGES-1:0] src;
    logic [NUM_STAGES-1:0] stall_mask;
    logic [NUM_STAGES-1:0] bubble_mask;
    logic [IW-1:0]         f_idx;
    logic [IW-1:0]         h_idx;
    logic                  f_valid;
    logic                  h_valid;
    logic                  flush_eff;
    logic [WD_W-1:0]       wd_cnt_reg;
    logic                  wd_qual;
    logic                  wd_fire;
    logic                  timeout_reg;
    logic [CNT_W-1:0]      stall_cnt_reg;

    // A wait is live from its start pulse until (and excluding) its done pulse.
    assign wait_act = (wait_start | wait_pend_reg) & ~wait_done;

    pipe_prio_enc #(.N(NUM_STAGES), .IW(IW)) u_flush_enc (
        .req   (flush_req),
        .idx   (f_idx),
        .valid (f_valid)
    );

    // Per-stage masks relative to the flushing stage F and the stall head H.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
        assign above_f[gi]    = f_valid && (IW'(gi) > f_idx);
        assign below_f[gi]    = f_valid && (IW'(gi) < f_idx);
        assign defer_src[gi]  = f_valid && !flush_eff && (IW'(gi) == f_idx);
        assign stall_mask[gi] = (IW'(gi) <= h_idx);
        if (gi == 0) begin : g_bub0
            assign bubble_mask[gi] = 1'b0;
        end else begin : g_bubn
            assign bubble_mask[gi] = (IW'(gi - 1) == h_idx);
        end
    end

    // Flush goes ahead only if nothing older is stalling, F itself is not
    // stalling, and no younger stage is waiting on the bus.
    assign flush_eff = f_valid
                    && !(|((stall_req | wait_act) & above_f))
                    && !stall_req[f_idx]
                    && !(|(wait_act & below_f));

    assign src = stall_req | wait_act | defer_src;

    pipe_prio_enc #(.N(NUM_STAGES), .IW(IW)) u_stall_enc (
        .req   (src),
        .idx   (h_idx),
        .valid (h_valid)
    );

    // Combinational hold / NOP controls, forced idle during reset.
    always_comb begin
        stall  = '0;
        bubble = '0;
        flush  = '0;
        if (!rst) begin
            if (flush_eff) begin
                flush = below_f;
            end else if (h_valid) begin
                stall  = stall_mask;
                bubble = bubble_mask;
            end
        end
    end

    assign wd_qual = (|wait_act) && !(|wait_done);
    assign wd_fire = (TIMEOUT_CYC != 0) && wd_qual && (wd_cnt_reg == WD_LAST);

    // Pending-wait flags and watchdog; a firing watchdog abandons all waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_pend_reg <= '0;
            wd_cnt_reg    <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= wd_fire;
            if (wd_fire) begin
                wait_pend_reg <= '0;
                wd_cnt_reg    <= '0;
            end else begin
                wait_pend_reg <= wait_act;
                wd_cnt_reg    <= (wd_qual && TIMEOUT_CYC != 0) ? wd_cnt_reg + WD_W'(1) : '0;
            end
        end
    end

    // Saturating count of cycles in which the fetch stage is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt_reg <= '0;
        end else if (stall[0] && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign wait_pend    = wait_pend_reg;
    assign wait_timeout = timeout_reg;
    assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (5 stages, 8-cycle watchdog, 4-bit counter).
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] stall_req = '0;
    logic [4:0] wait_start = '0;
    logic [4:0] wait_done = '0;
    logic [4:0] flush_req = '0;
    logic       stall_cnt_clr = 1'b0;
    logic [4:0] stall;
    logic [4:0] bubble;
    logic [4:0] flush;
    logic [4:0] wait_pend;
    logic       wait_timeout;
    logic [3:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stall_ctrl #(.NUM_STAGES(5), .TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .wait_start    (wait_start),
        .wait_done     (wait_done),
        .flush_req     (flush_req),
        .stall_cnt_clr (stall_cnt_clr),
        .stall         (stall),
        .bubble        (bubble),
        .flush         (flush),
        .wait_pend     (wait_pend),
        .wait_timeout  (wait_timeout),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_req = '0; wait_start = '0; wait_done = '0; flush_req = '0; stall_cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_req = 5'b11111;
        repeat (2) next_cycle();
        #2;
        checks++; if ({stall, bubble, flush} !== 15'd0) begin errors++;
            $display("FAIL reset_ctrl got=%b/%b/%b exp=0", stall, bubble, flush); end
        checks++; if ({wait_pend, wait_timeout, stall_cnt} !== 10'd0) begin errors++;
            $display("FAIL reset_regs pend=%b to=%b cnt=%0d exp=0", wait_pend, wait_timeout, stall_cnt); end
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        stall_req = 5'b00010;
        #2;
        checks++; if (stall !== 5'b00011) begin errors++; $display("FAIL lu_stall got=%b exp=00011", stall); end
        checks++; if (bubble !== 5'b00100) begin errors++; $display("FAIL lu_bubble got=%b exp=00100", bubble); end
        checks++; if (flush !== 5'b00000) begin errors++; $display("FAIL lu_flush got=%b exp=00000", flush); end
        next_cycle();
        stall_req = '0;
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        $display("test_load_use done");
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) wait_start = 5'b01000;
            if (c == 3) wait_done  = 5'b01000;
            #2;
            if (c < 3) begin
                checks++; if (stall !== 5'b01111 || bubble !== 5'b10000) begin errors++;
                    $display("FAIL mem_wait_c%0d got=%b/%b exp=01111/10000", c, stall, bubble); end
            end else begin
                checks++; if (stall !== 5'b0 || bubble !== 5'b0 || flush !== 5'b0) begin errors++;
                    $display("FAIL mem_rel_c%0d got=%b/%b/%b exp=0", c, stall, bubble, flush); end
            end
            if (c == 1) begin
                checks++; if (wait_pend !== 5'b01000) begin errors++; $display("FAIL mem_pend got=%b exp=01000", wait_pend); end
            end
            if (c == 4) begin
                checks++; if (wait_pend !== 5'b00000) begin errors++; $display("FAIL mem_pend_drop got=%b exp=00000", wait_pend); end
            end
            next_cycle();
        end
        clear_inputs();
        $display("test_mem_wait done");
    endtask

    task automatic test_flush_deferred();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            if (c == 0) wait_start = 5'b00001;
            if (c >= 1) flush_req  = 5'b00100;
            if (c == 4) wait_done  = 5'b00001;
            #2;
            if (c == 0) begin
                checks++; if (stall !== 5'b00001 || bubble !== 5'b00010) begin errors++;
                    $display("FAIL fd_start got=%b/%b exp=00001/00010", stall, bubble); end
            end else if (c < 4) begin
                checks++; if (stall !== 5'b00111 || bubble !== 5'b01000 || flush !== 5'b0) begin errors++;
                    $display("FAIL fd_hold_c%0d got=%b/%b/%b exp=00111/01000/00000", c, stall, bubble, flush); end
            end else begin
                checks++; if (flush !== 5'b00011 || stall !== 5'b0 || bubble !== 5'b0) begin errors++;
                    $display("FAIL fd_go got=%b/%b/%b exp=00011/00000/00000", flush, stall, bubble); end
            end
            next_cycle();
        end
        clear_inputs();
        $display("test_flush_deferred done");
    endtask

    task automatic test_flush_arb();
        // Flush beats a younger combinational stall.
        stall_req = 5'b00010; flush_req = 5'b00100;
        #2;
        checks++; if (flush !== 5'b00011 || stall !== 5'b0 || bubble !== 5'b0) begin errors++;
            $display("FAIL fa_beat got=%b/%b/%b exp=00011/00000/00000", flush, stall, bubble); end
        // Older stall blocks the flush.
        stall_req = 5'b01000; flush_req = 5'b00100;
        #2;
        checks++; if (stall !== 5'b01111 || bubble !== 5'b10000 || flush !== 5'b0) begin errors++;
            $display("FAIL fa_older got=%b/%b/%b exp=01111/10000/00000", stall, bubble, flush); end
        // Stall at F itself defers the flush.
        stall_req = 5'b00100; flush_req = 5'b00100;
        #2;
        checks++; if (stall !== 5'b00111 || bubble !== 5'b01000 || flush !== 5'b0) begin errors++;
            $display("FAIL fa_self got=%b/%b/%b exp=00111/01000/00000", stall, bubble, flush); end
        // WB stall: no bubble beyond the oldest stage.
        stall_req = 5'b10000; flush_req = 5'b00000;
        #2;
        checks++; if (stall !== 5'b11111 || bubble !== 5'b00000) begin errors++;
            $display("FAIL fa_wb got=%b/%b exp=11111/00000", stall, bubble); end
        // Flush from WB kills all younger stages.
        stall_req = 5'b00011; flush_req = 5'b10000;
        #2;
        checks++; if (flush !== 5'b01111 || stall !== 5'b0) begin errors++;
            $display("FAIL fa_wbflush got=%b/%b exp=01111/00000", flush, stall); end
        // Flush from IF has nobody younger.
        stall_req = 5'b00000; flush_req = 5'b00001;
        #2;
        checks++; if (flush !== 5'b00000 || stall !== 5'b0 || bubble !== 5'b0) begin errors++;
            $display("FAIL fa_if got=%b/%b/%b exp=0", flush, stall, bubble); end
        clear_inputs();
        next_cycle();
        $display("test_flush_arb done");
    endtask

    task automatic test_zero_len();
        wait_start = 5'b01000; wait_done = 5'b01000;
        #2;
        checks++; if (stall !== 5'b0 || bubble !== 5'b0) begin errors++;
            $display("FAIL zl_ctrl got=%b/%b exp=0", stall, bubble); end
        next_cycle();
        clear_inputs();
        wait_done = 5'b00100;
        #2;
        checks++; if (wait_pend !== 5'b0 || stall !== 5'b0) begin errors++;
            $display("FAIL zl_pend got=%b/%b exp=0", wait_pend, stall); end
        next_cycle();
        clear_inputs();
        checks++; if (wait_pend !== 5'b0) begin errors++; $display("FAIL zl_done_only got=%b exp=0", wait_pend); end
        $display("test_zero_len done");
    endtask

    task automatic test_watchdog();
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            if (c == 0) wait_start = 5'b01000;
            #2;
            if (c < 8) begin
                checks++; if (wait_timeout !== 1'b0) begin errors++; $display("FAIL wd_early_c%0d got=%b exp=0", c, wait_timeout); end
            end
            if (c == 7) begin
                checks++; if (stall !== 5'b01111) begin errors++; $display("FAIL wd_stall7 got=%b exp=01111", stall); end
            end
            if (c == 8) begin
                checks++; if (wait_timeout !== 1'b1) begin errors++; $display("FAIL wd_pulse got=%b exp=1", wait_timeout); end
            end
            if (c == 9) begin
                checks++; if (wait_timeout !== 1'b0) begin errors++; $display("FAIL wd_pulse_end got=%b exp=0", wait_timeout); end
                checks++; if (stall !== 5'b0 || wait_pend !== 5'b0) begin errors++;
                    $display("FAIL wd_release got=%b/%b exp=0/0", stall, wait_pend); end
            end
            next_cycle();
        end
        clear_inputs();
        $display("test_watchdog done");
    endtask

    task automatic test_counter();
        stall_cnt_clr = 1'b1;
        next_cycle();
        stall_cnt_clr = 1'b0;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_clr0 got=%0d exp=0", stall_cnt); end
        stall_req = 5'b00001;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            if (c == 14) begin
                checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL cnt_14 got=%0d exp=14", stall_cnt); end
            end
            if (c == 15) begin
                checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_15 got=%0d exp=15", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat got=%0d exp=15", stall_cnt); end
        stall_cnt_clr = 1'b1;
        next_cycle();
        stall_cnt_clr = 1'b0;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_clr_wins got=%0d exp=0", stall_cnt); end
        clear_inputs();
        $display("test_counter done");
    endtask

    task automatic test_async_reset();
        wait_start = 5'b01000;
        next_cycle();
        wait_start = '0;
        stall_req = 5'b00010;
        #2;
        checks++; if (wait_pend !== 5'b01000) begin errors++; $display("FAIL ar_pend_pre got=%b exp=01000", wait_pend); end
        rst = 1'b1;
        stall_req = 5'b11111;
        #1;
        checks++; if (wait_pend !== 5'b0 || stall_cnt !== 4'd0 || wait_timeout !== 1'b0) begin errors++;
            $display("FAIL ar_regs pend=%b cnt=%0d to=%b exp=0", wait_pend, stall_cnt, wait_timeout); end
        checks++; if (stall !== 5'b0 || bubble !== 5'b0 || flush !== 5'b0) begin errors++;
            $display("FAIL ar_ctrl got=%b/%b/%b exp=0", stall, bubble, flush); end
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        #2;
        checks++; if (wait_pend !== 5'b0 || stall !== 5'b0) begin errors++;
            $display("FAIL ar_after got=%b/%b exp=0/0", wait_pend, stall); end
        next_cycle();
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_flush_deferred();
        test_flush_arb();
        test_zero_len();
        test_watchdog();
        test_counter();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
